// File: rtl/prod_accum_if.sv
// prod_accum_if
// Bundles the two valid/ready handshakes around the product accumulator.
// The input side carries 16-bit signed products from the multiplier glue.
// The output side carries completed, saturated sums and their sticky saturation flag.
//
// Ports and modports:
//   ACC_W     : width of the result bus
//   in_valid  : in_data holds a product (producer -> accumulator)
//   in_data   : signed 16-bit product (producer -> accumulator)
//   in_ready  : accumulator accepts a product this cycle (accumulator -> producer)
//   out_valid : out_data/sat hold a completed result (accumulator -> consumer)
//   out_data  : signed saturated sum (accumulator -> consumer)
//   sat       : saturation occurred during this result (accumulator -> consumer)
//   out_ready : consumer takes the result this cycle (consumer -> accumulator)
//   slave     : the accumulator's view of the bus
//   master    : the surrounding logic's view (drives products, takes results)
interface prod_accum_if #(
  parameter int ACC_W = 24
);
  logic                    in_valid;
  logic signed [15:0]      in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    sat;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat
  );
endinterface

// File: rtl/prod_accum.sv
// prod_accum
// Sums N consecutive signed 16-bit products into a saturating ACC_W-bit result.
// It presents each finished sum, held until the consumer takes it.
//
// Parameters:
//   N     : products per result (1..255)
//   ACC_W : accumulator/result width (16..32)
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : prod_accum_if.slave (product input handshake, result output handshake)
module prod_accum #(
  parameter int N     = 4,
  parameter int ACC_W = 24
) (
  input  logic         clk,
  input  logic         rst,
  prod_accum_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  // Saturation bounds, expressed one bit wider than the accumulator so the
  // raw sum can be compared against them without overflow.
  localparam logic signed [ACC_W:0] MAX_S = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_S = {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    sat_int_q, sat_int_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_clamped;
  logic                    clamp_hi;
  logic                    clamp_lo;
  logic                    accept;
  logic                    last_beat;

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat       = sat_q;

  // Saturating adder: both operands are sign-extended to ACC_W+1 bits.
  // That width holds any acc + product without wrap, so overflow is detected
  // by comparing against the widened bounds.
  always_comb begin
    sum_wide    = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){bus.in_data[15]}}, bus.in_data};
    clamp_hi    = (sum_wide > MAX_S);
    clamp_lo    = (sum_wide < MIN_S);
    sum_clamped = sum_wide[ACC_W-1:0];
    if (clamp_hi) begin
      sum_clamped = MAX_S[ACC_W-1:0];
    end else if (clamp_lo) begin
      sum_clamped = MIN_S[ACC_W-1:0];
    end
  end

  assign accept    = bus.in_valid && (state_q == ACC);
  assign last_beat = (count_q == CW'(N - 1));

  // Next-state logic. The final beat of a batch bypasses the accumulator and
  // writes the clamped sum straight into the output register.
  // acc/count/sat_int are cleared on that same edge, so the next batch starts
  // clean as soon as the result has been taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_int_d   = sat_int_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      INIT: begin
        acc_d     = '0;
        count_d   = '0;
        sat_int_d = 1'b0;
        state_d   = ACC;
      end
      ACC: begin
        if (accept) begin
          if (last_beat) begin
            out_data_d  = sum_clamped;
            sat_d       = sat_int_q | clamp_hi | clamp_lo;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            sat_int_d   = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d     = sum_clamped;
            count_d   = count_q + CW'(1);
            sat_int_d = sat_int_q | clamp_hi | clamp_lo;
          end
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // State registers; reset aborts any partial batch and any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      acc_q       <= '0;
      count_q     <= '0;
      sat_int_q   <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_int_q   <= sat_int_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum
// Directed testbench for prod_accum.
// It drives a default instance (N=4, ACC_W=24) and a narrow instance
// (N=4, ACC_W=16) used for saturation cases.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prod_accum_if #(.ACC_W(24)) a_if ();
  prod_accum_if #(.ACC_W(16)) b_if ();

  prod_accum #(.N(4), .ACC_W(24)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  prod_accum #(.N(4), .ACC_W(16)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int tests_run    = 0;
  int tests_failed = 0;

  // Present one product for one cycle and return on the next falling edge.
  // The DUT must be in ACC when this is called.
  task automatic push_a(input logic signed [15:0] v);
    a_if.in_valid = 1'b1;
    a_if.in_data  = v;
    @(negedge clk);
    a_if.in_valid = 1'b0;
  endtask

  task automatic push_b(input logic signed [15:0] v);
    b_if.in_valid = 1'b1;
    b_if.in_data  = v;
    @(negedge clk);
    b_if.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", a_if.out_valid); end
    tests_run++;
    if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 0", a_if.in_ready); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL init_cycle_in_ready: got %b want 0", a_if.in_ready); end
    @(negedge clk);
    tests_run++;
    if (a_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL acc_cycle_in_ready_a: got %b want 1", a_if.in_ready); end
    tests_run++;
    if (b_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL acc_cycle_in_ready_b: got %b want 1", b_if.in_ready); end
  endtask

  task automatic test_basic_sum;
    a_if.out_ready = 1'b0;
    push_a(16'sd100);
    push_a(-16'sd50);
    push_a(16'sd32767);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid: got %b want 0", a_if.out_valid); end
    push_a(-16'sd32768);
    tests_run++;
    if (a_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid: got %b want 1", a_if.out_valid); end
    tests_run++;
    if (a_if.out_data !== 24'sd49) begin tests_failed++; $display("[TB] FAIL basic_data: got %0d want 49", a_if.out_data); end
    tests_run++;
    if (a_if.sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_sat: got %b want 0", a_if.sat); end
    tests_run++;
    if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_done_in_ready: got %b want 0", a_if.in_ready); end
  endtask

  // Reset asserted between clock edges while a result is pending.
  // Outputs must drop without waiting for an edge.
  task automatic test_async_reset;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_valid: got %b want 0", a_if.out_valid); end
    tests_run++;
    if (a_if.out_data !== 24'sd0) begin tests_failed++; $display("[TB] FAIL async_rst_data: got %0d want 0", a_if.out_data); end
    tests_run++;
    if (a_if.sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_sat: got %b want 0", a_if.sat); end
    tests_run++;
    if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_rst_in_ready: got %b want 0", a_if.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (a_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_rst_recover: got %b want 1", a_if.in_ready); end
  endtask

  task automatic test_backpressure;
    a_if.out_ready = 1'b0;
    push_a(16'sd1000);
    push_a(16'sd200);
    push_a(16'sd30);
    push_a(16'sd4);
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_data  = 16'sh7abc;
      @(negedge clk);
      tests_run++;
      if (a_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, a_if.out_valid); end
      tests_run++;
      if (a_if.out_data !== 24'sd1234) begin tests_failed++; $display("[TB] FAIL bp_data[%0d]: got %0d want 1234", i, a_if.out_data); end
      tests_run++;
      if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, a_if.in_ready); end
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_valid: got %b want 0", a_if.out_valid); end
    tests_run++;
    if (a_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_in_ready: got %b want 1", a_if.in_ready); end
    tests_run++;
    if (a_if.out_data !== 24'sd1234) begin tests_failed++; $display("[TB] FAIL bp_data_kept: got %0d want 1234", a_if.out_data); end
  endtask

  // With out_ready held high the result leaves after one DONE cycle.
  // The next cycle is back in ACC.
  task automatic test_back_to_back;
    a_if.out_ready = 1'b1;
    repeat (4) push_a(16'sd1);
    tests_run++;
    if (a_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid: got %b want 1", a_if.out_valid); end
    tests_run++;
    if (a_if.out_data !== 24'sd4) begin tests_failed++; $display("[TB] FAIL b2b_data: got %0d want 4", a_if.out_data); end
    tests_run++;
    if (a_if.in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_gap_in_ready: got %b want 0", a_if.in_ready); end
    @(negedge clk);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_valid_drop: got %b want 0", a_if.out_valid); end
    tests_run++;
    if (a_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_in_ready: got %b want 1", a_if.in_ready); end
  endtask

  task automatic test_saturation;
    b_if.out_ready = 1'b1;
    repeat (4) push_b(16'sd32767);
    tests_run++;
    if (b_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_pos_valid: got %b want 1", b_if.out_valid); end
    tests_run++;
    if (b_if.out_data !== 16'sd32767) begin tests_failed++; $display("[TB] FAIL sat_pos_data: got %0d want 32767", b_if.out_data); end
    tests_run++;
    if (b_if.sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_pos_flag: got %b want 1", b_if.sat); end
    @(negedge clk);
    repeat (4) push_b(-16'sd32768);
    tests_run++;
    if (b_if.out_data !== -16'sd32768) begin tests_failed++; $display("[TB] FAIL sat_neg_data: got %0d want -32768", b_if.out_data); end
    tests_run++;
    if (b_if.sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_neg_flag: got %b want 1", b_if.sat); end
    @(negedge clk);
    push_b(16'sd1); push_b(16'sd2); push_b(16'sd3); push_b(16'sd4);
    tests_run++;
    if (b_if.out_data !== 16'sd10) begin tests_failed++; $display("[TB] FAIL sat_clear_data: got %0d want 10", b_if.out_data); end
    tests_run++;
    if (b_if.sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL sat_clear_flag: got %b want 0", b_if.sat); end
    @(negedge clk);
    push_b(16'sd32767); push_b(16'sd1); push_b(-16'sd100); push_b(16'sd0);
    tests_run++;
    if (b_if.out_data !== 16'sd32667) begin tests_failed++; $display("[TB] FAIL sat_sticky_data: got %0d want 32667", b_if.out_data); end
    tests_run++;
    if (b_if.sat !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_sticky_flag: got %b want 1", b_if.sat); end
    @(negedge clk);
  endtask

  task automatic test_bubbles;
    a_if.out_ready = 1'b1;
    push_a(16'sd10);
    push_a(16'sd20);
    repeat (2) @(negedge clk);
    push_a(16'sd30);
    repeat (3) @(negedge clk);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bubble_early_valid: got %b want 0", a_if.out_valid); end
    push_a(16'sd40);
    tests_run++;
    if (a_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bubble_valid: got %b want 1", a_if.out_valid); end
    tests_run++;
    if (a_if.out_data !== 24'sd100) begin tests_failed++; $display("[TB] FAIL bubble_data: got %0d want 100", a_if.out_data); end
    @(negedge clk);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bubble_valid_drop: got %b want 0", a_if.out_valid); end
  endtask

  task automatic test_reset_mid_batch;
    a_if.out_ready = 1'b1;
    push_a(16'sd500);
    push_a(16'sd600);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (a_if.out_data !== 24'sd0) begin tests_failed++; $display("[TB] FAIL midrst_data: got %0d want 0", a_if.out_data); end
    @(negedge clk);
    tests_run++;
    if (a_if.in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_in_ready: got %b want 1", a_if.in_ready); end
    push_a(16'sd1); push_a(16'sd2); push_a(16'sd3);
    tests_run++;
    if (a_if.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_early_valid: got %b want 0", a_if.out_valid); end
    push_a(16'sd4);
    tests_run++;
    if (a_if.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_valid: got %b want 1", a_if.out_valid); end
    tests_run++;
    if (a_if.out_data !== 24'sd10) begin tests_failed++; $display("[TB] FAIL midrst_data_sum: got %0d want 10", a_if.out_data); end
    tests_run++;
    if (a_if.sat !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_sat: got %b want 0", a_if.sat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic_sum;
    test_async_reset;
    test_backpressure;
    test_back_to_back;
    test_saturation;
    test_bubbles;
    test_reset_mid_batch;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/prod_accum.md
# prod_accum

Sequential signed accumulator that sits directly downstream of the 8x8 signed sequential multiplier. It consumes its 16-bit signed products over a valid/ready handshake and sums N consecutive products into a saturating ACC_W-bit result. It presents each completed sum, which is one dot-product term group, over a second valid/ready handshake. The multiplier glue drives `in_valid` for one cycle per completed product.

## Interface
- `N`, default 4: products per result; legal range 1..255.
- `ACC_W`, default 24: accumulator and result width; legal range 16..32.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high; clock `clk`.
- `in_valid` input 1: `in_data` holds a product.
- `in_data` input 16: signed two's-complement product.
- `in_ready` output 1: block accepts a product this cycle.
- `out_valid` output 1: `out_data` and `sat` hold a completed result.
- `out_data` output ACC_W: signed saturated sum of N products.
- `out_ready` input 1: consumer takes the result this cycle.
- `sat` output 1: saturation occurred at least once during this result.

## Operation
- States:
  - INIT: clears the accumulator.
  - ACC: accepts products.
  - DONE: holds the result.
- Reset forces INIT and sets to 0: `acc`, `count`, `sat_int`, `out_data`, `sat`, `out_valid`.
- `in_ready` = (state == ACC). It is combinational from the state register only and never depends on `in_valid`.
- INIT → ACC on the next clock, unconditionally. Entering INIT again sets `acc`=0, `count`=0, `sat_int`=0.
- ACC, on an accept (`in_valid && in_ready`):
  - Compute `s` = `acc` + sign-extend(`in_data`) at ACC_W+1 bits.
  - If `s` > 2^(ACC_W-1)-1: clamp to that value and set `sat_int`.
  - If `s` < -2^(ACC_W-1): clamp to that value and set `sat_int`.
  - `count` increments; its width is $clog2(N+1).
- Last accept of a batch (`count == N-1` at the accept): the clamped sum goes to `out_data`, `sat` takes `sat_int` OR this beat's clamp, `out_valid` is set, and the state moves to DONE.
  - On this beat the accumulator is cleared rather than updated.
  - `count` resets to 0 and `sat_int` clears.
- ACC with no accept: state is unchanged.
- DONE:
  - `in_ready`=0; `in_data` and `in_valid` are ignored.
  - `out_valid` stays high. `out_data` and `sat` are stable until `out_ready` is sampled high.
  - On `out_valid && out_ready`: `out_valid` drops and the state returns to ACC.
- `out_data` and `sat` keep their last value after the handshake, until the next result.
- N=1: every accept produces a result. Saturation is impossible for ACC_W ≥ 16, so `sat`=0 always.
- Saturation is sticky within a batch. A later beat that moves the sum back into range does not clear `sat`.
- `rst` asserted in any state aborts the current batch and clears any partial sum. No result is emitted for the aborted batch.

## Timing
- First cycle after `rst` deasserts: INIT, `in_ready`=0. Second cycle: ACC, `in_ready`=1.
- Throughput: one product per cycle while in ACC.
- Latency: `out_valid` is high the cycle after the Nth accepting edge.
- Back-to-back batches: the cycle after the output handshake, `in_ready`=1. The minimum gap between batches is therefore one cycle with `in_ready` low. That cycle is the DONE cycle when `out_ready` is already high.
- `in_valid` may drop at any time in ACC with no effect beyond stalling.
- `out_ready` may be held high permanently. The result then leaves after exactly one DONE cycle.

## Test plan
- Reset:
  - Assert `rst` mid-clock; all outputs go 0 immediately, without waiting for a clock edge.
  - `in_ready` stays 0 for one cycle after release, then reads 1.
- Basic sum (N=4, ACC_W=24):
  - Products 100, -50, 32767, -32768 on consecutive cycles.
  - Expect `out_data`=49, `sat`=0, `out_valid` high the cycle after the 4th accept.
- Backpressure:
  - Complete a batch with sum 1234 while holding `out_ready`=0 for 5 cycles, driving `in_valid`=1 with junk data.
  - Expect `out_valid` held, `out_data`=1234 stable, and `in_ready`=0 throughout.
  - The next batch (1,1,1,1) yields 4.
- Saturation (ACC_W=16 instance):
  - Four products of 32767: expect `out_data`=32767, `sat`=1.
  - Then four of -32768: expect -32768, `sat`=1.
  - Then 1,2,3,4: expect 10, `sat`=0.
  - Also 32767, 1, -100, 0: expect 32667, `sat`=1 (sticky).
- Bubbles:
  - Products 10, 20, 30, 40 with 0–3 idle cycles between them.
  - Expect 100, with `out_valid` exactly one cycle after the 40 is accepted.
- Reset mid-batch:
  - Accept 500 and 600, pulse `rst`, then send 1, 2, 3, 4.
  - Expect 10 (no residue) and no result emitted for the aborted batch.
